// File: rtl/addsub_pkg.sv
// Shared types and sizing helpers for the iterative adder/subtractor.
// Slice count and index width are derived here so the top and bench agree.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-slice build still needs a 1-bit index register.
  function automatic int idx_width(input int width, input int chunk);
    int n;
    n = width / chunk;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/addsub_iter_cla_slice.sv
// Combinational CHUNK-bit carry-lookahead adder; exposes the carry into the
// top bit so the caller can form signed overflow.
module cla_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK-1:0] p;
  logic [CHUNK-1:0] g;
  logic [CHUNK:0]   c;
  logic             cc;
  logic             pp;

  assign p = a ^ b;
  assign g = a & b;

  // Each carry is a flat sum of products over generate/propagate terms.
  always_comb begin
    cc   = 1'b0;
    pp   = 1'b0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      cc = g[i];
      pp = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        cc = cc | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = cc | (pp & cin);
    end
  end

  assign sum   = p ^ c[CHUNK-1:0];
  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/addsub_iter.sv
// Multi-cycle WIDTH-bit add/subtract, one CHUNK-bit slice per clock through a
// shared lookahead slice; busy and done are registered one cycle behind the FSM.
module addsub_iter
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int             NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int             IW     = idx_width(WIDTH, CHUNK);
  localparam logic [IW-1:0]  LAST   = IW'(NCHUNK - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_next;
  logic [IW-1:0]    idx;
  logic             cy;
  logic [CHUNK-1:0] sa;
  logic [CHUNK-1:0] sb;
  logic [CHUNK-1:0] ssum;
  logic             scout;
  logic             smsb;
  int               base;

  always_comb begin
    base     = int'(idx) * CHUNK;
    sa       = a_q[base +: CHUNK];
    sb       = b_q[base +: CHUNK];
    res_next = result;
    res_next[base +: CHUNK] = ssum;
  end

  cla_slice #(.CHUNK(CHUNK)) u_slice (
    .a     (sa),
    .b     (sb),
    .cin   (cy),
    .sum   (ssum),
    .cout  (scout),
    .c_msb (smsb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b1;
      negative <= 1'b0;
      idx      <= '0;
      cy       <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      busy <= (state == RUN);
      done <= (state == DONE);
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // Subtract is A + ~B with the +1 entering as the slice-0 carry.
            a_q   <= a;
            b_q   <= b ^ {WIDTH{op == OP_SUB}};
            cy    <= (op == OP_SUB);
            idx   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          result <= res_next;
          cy     <= scout;
          if (idx == LAST) begin
            state    <= DONE;
            idx      <= '0;
            carry    <= scout;
            overflow <= smsb ^ scout;
            zero     <= (res_next == '0);
            negative <= res_next[WIDTH-1];
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_iter.sv
// Directed and model-checked bench for addsub_iter at 32/8, 16/16 and 32/4.
module tb_addsub_iter;
  import addsub_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start0, op0, busy0, done0, carry0, ovf0, zero0, neg0;
  logic [31:0] a0, b0, result0;
  logic        start1, op1, busy1, done1, carry1, ovf1, zero1, neg1;
  logic [15:0] a1, b1, result1;
  logic        start2, op2, busy2, done2, carry2, ovf2, zero2, neg2;
  logic [31:0] a2, b2, result2;

  addsub_iter #(.WIDTH(32), .CHUNK(8)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .op(op0), .a(a0), .b(b0),
    .busy(busy0), .done(done0), .result(result0), .carry(carry0),
    .overflow(ovf0), .zero(zero0), .negative(neg0));

  addsub_iter #(.WIDTH(16), .CHUNK(16)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op(op1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .result(result1), .carry(carry1),
    .overflow(ovf1), .zero(zero1), .negative(neg1));

  addsub_iter #(.WIDTH(32), .CHUNK(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .op(op2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .result(result2), .carry(carry2),
    .overflow(ovf2), .zero(zero2), .negative(neg2));

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cur      = 0;
  logic m_busy, m_done;

  always_comb begin
    case (cur)
      1:       begin m_busy = busy1; m_done = done1; end
      2:       begin m_busy = busy2; m_done = done2; end
      default: begin m_busy = busy0; m_done = done0; end
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic s, input logic o,
                       input logic [31:0] a, input logic [31:0] b);
    case (sel)
      1:       begin start1 = s; op1 = o; a1 = a[15:0]; b1 = b[15:0]; end
      2:       begin start2 = s; op2 = o; a2 = a; b2 = b; end
      default: begin start0 = s; op0 = o; a0 = a; b0 = b; end
    endcase
  endtask

  // One accepted operation; k counts cycles after the accepting edge.
  task automatic do_op(input int sel, input logic o, input logic [31:0] a,
                       input logic [31:0] b, input int ncyc,
                       output int done_at, output int busy_cnt,
                       output int n_done, output int overlap);
    cur = sel;
    done_at = -1; busy_cnt = 0; n_done = 0; overlap = 0;
    drive(sel, 1'b1, o, a, b);
    tick();
    drive(sel, 1'b0, o, a, b);
    for (int k = 0; k < ncyc; k++) begin
      if (m_busy) busy_cnt++;
      if (m_done) begin
        n_done++;
        if (done_at < 0) done_at = k;
      end
      if (m_busy && m_done) overlap++;
      if (k < ncyc - 1) tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy0); end
    n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done0); end
    n_checks++; if (result0 !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result0); end
    n_checks++; if ({carry0, ovf0, neg0} !== 3'b000) begin n_fail++; $display("FAIL reset_cvn: got %b want 000", {carry0, ovf0, neg0}); end
    n_checks++; if (zero0 !== 1'b1) begin n_fail++; $display("FAIL reset_zero: got %b want 1", zero0); end
    rst = 1'b0;
    tick();
    n_checks++; if ({busy0, done0, zero0} !== 3'b001) begin n_fail++; $display("FAIL post_reset_idle: got %b want 001", {busy0, done0, zero0}); end
  endtask

  task automatic test_add_overflow();
    int d, bc, nd, ov;
    do_op(0, OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 8, d, bc, nd, ov);
    n_checks++; if (result0 !== 32'h8000_0000) begin n_fail++; $display("FAIL add_result: got %h want 80000000", result0); end
    n_checks++; if ({carry0, ovf0, zero0, neg0} !== 4'b0101) begin n_fail++; $display("FAIL add_flags cvzn: got %b want 0101", {carry0, ovf0, zero0, neg0}); end
    n_checks++; if (d !== 5) begin n_fail++; $display("FAIL add_latency: got %0d want 5", d); end
    n_checks++; if (bc !== 4) begin n_fail++; $display("FAIL add_busy_cycles: got %0d want 4", bc); end
    n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL add_done_count: got %0d want 1", nd); end
    n_checks++; if (ov !== 0) begin n_fail++; $display("FAIL add_busy_done_overlap: got %0d want 0", ov); end
  endtask

  task automatic test_sub();
    int d, bc, nd, ov;
    do_op(0, OP_SUB, 32'd5, 32'd7, 8, d, bc, nd, ov);
    n_checks++; if (result0 !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sub_borrow_result: got %h want fffffffe", result0); end
    n_checks++; if ({carry0, ovf0, zero0, neg0} !== 4'b0001) begin n_fail++; $display("FAIL sub_borrow_flags cvzn: got %b want 0001", {carry0, ovf0, zero0, neg0}); end
    do_op(0, OP_SUB, 32'h1234_5678, 32'h1234_5678, 8, d, bc, nd, ov);
    n_checks++; if (result0 !== 32'h0) begin n_fail++; $display("FAIL sub_equal_result: got %h want 0", result0); end
    n_checks++; if ({carry0, ovf0, zero0, neg0} !== 4'b1010) begin n_fail++; $display("FAIL sub_equal_flags cvzn: got %b want 1010", {carry0, ovf0, zero0, neg0}); end
    n_checks++; if (d !== 5) begin n_fail++; $display("FAIL sub_latency: got %0d want 5", d); end
  endtask

  task automatic test_start_held();
    int nd, d;
    nd = 0; d = -1; cur = 0;
    drive(0, 1'b1, OP_ADD, 32'd1, 32'd2);
    tick();
    for (int k = 0; k < 12; k++) begin
      if (done0) begin nd++; if (d < 0) d = k; end
      if (k < 4) drive(0, 1'b1, OP_SUB, 32'hDEAD_0000 + 32'(k), 32'h1234);
      else       drive(0, 1'b0, OP_ADD, 32'd0, 32'd0);
      tick();
    end
    n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL held_done_count: got %0d want 1", nd); end
    n_checks++; if (d !== 5) begin n_fail++; $display("FAIL held_latency: got %0d want 5", d); end
    n_checks++; if (result0 !== 32'd3) begin n_fail++; $display("FAIL held_result: got %h want 3", result0); end
  endtask

  task automatic test_back_to_back();
    int nd;
    int d[2];
    nd = 0; d[0] = -1; d[1] = -1; cur = 0;
    drive(0, 1'b1, OP_ADD, 32'd10, 32'd20);
    tick();
    for (int k = 0; k < 13; k++) begin
      if (done0) begin
        if (nd < 2) d[nd] = k;
        if (nd == 0) begin
          n_checks++; if (result0 !== 32'd30) begin n_fail++; $display("FAIL b2b_first_result: got %h want 1e", result0); end
        end else begin
          n_checks++; if (result0 !== 32'd99) begin n_fail++; $display("FAIL b2b_second_result: got %h want 63", result0); end
        end
        nd++;
      end
      if (k == 4) drive(0, 1'b1, OP_SUB, 32'd100, 32'd1);
      else        drive(0, 1'b0, OP_ADD, 32'd0, 32'd0);
      tick();
    end
    n_checks++; if (nd !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", nd); end
    n_checks++; if (d[0] !== 5 || d[1] !== 10) begin n_fail++; $display("FAIL b2b_done_cycles: got %0d,%0d want 5,10", d[0], d[1]); end
  endtask

  task automatic test_reset_mid();
    int nd, d, bc, ov;
    cur = 0;
    drive(0, 1'b1, OP_ADD, 32'h1111_1111, 32'h2222_2222);
    tick();
    drive(0, 1'b0, OP_ADD, 32'd0, 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();
    n_checks++; if ({busy0, done0} !== 2'b00) begin n_fail++; $display("FAIL midrst_busy_done: got %b want 00", {busy0, done0}); end
    n_checks++; if (result0 !== 32'h0 || zero0 !== 1'b1) begin n_fail++; $display("FAIL midrst_result_zero: got %h/%b want 0/1", result0, zero0); end
    rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done0 || busy0) nd++;
    end
    n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d active cycles want 0", nd); end
    do_op(0, OP_SUB, 32'h8000_0000, 32'd1, 8, d, bc, nd, ov);
    n_checks++; if (result0 !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL midrst_fresh_result: got %h want 7fffffff", result0); end
    n_checks++; if ({carry0, ovf0, zero0, neg0} !== 4'b1100) begin n_fail++; $display("FAIL midrst_fresh_flags cvzn: got %b want 1100", {carry0, ovf0, zero0, neg0}); end
  endtask

  task automatic test_single_slice();
    int d, bc, nd, ov;
    do_op(1, OP_ADD, 32'h0000_FFFF, 32'h0000_0001, 5, d, bc, nd, ov);
    n_checks++; if (result1 !== 16'h0) begin n_fail++; $display("FAIL single_result: got %h want 0", result1); end
    n_checks++; if ({carry1, ovf1, zero1, neg1} !== 4'b1010) begin n_fail++; $display("FAIL single_flags cvzn: got %b want 1010", {carry1, ovf1, zero1, neg1}); end
    n_checks++; if (d !== 2) begin n_fail++; $display("FAIL single_latency: got %0d want 2", d); end
    n_checks++; if (bc !== 1) begin n_fail++; $display("FAIL single_busy_cycles: got %0d want 1", bc); end
  endtask

  task automatic test_random_chunk4();
    int          d, bc, nd, ov;
    logic        o;
    logic [31:0] a, b, bb, er;
    logic [32:0] s33;
    logic        ec, ev;
    for (int i = 0; i < 1000; i++) begin
      o = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      if (i == 0) begin a = 32'h8000_0000; b = 32'h8000_0000; o = OP_ADD; end
      if (i == 1) begin a = 32'h0; b = 32'h0; o = OP_SUB; end
      bb  = o ? ~b : b;
      s33 = {1'b0, a} + {1'b0, bb} + {32'd0, o};
      er  = s33[31:0];
      ec  = s33[32];
      ev  = (a[31] == bb[31]) && (er[31] != a[31]);
      do_op(2, o, a, b, 11, d, bc, nd, ov);
      n_checks++;
      if ({result2, carry2, ovf2, zero2, neg2} !== {er, ec, ev, er == 32'h0, er[31]} || d !== 9) begin
        n_fail++;
        $display("FAIL rand4 #%0d op=%b a=%h b=%h: got %h cvzn=%b done@%0d want %h cvzn=%b done@9",
                 i, o, a, b, result2, {carry2, ovf2, zero2, neg2}, d,
                 er, {ec, ev, er == 32'h0, er[31]});
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(2, 1'b0, 1'b0, 32'd0, 32'd0);
    test_reset();
    test_add_overflow();
    test_sub();
    test_start_held();
    test_back_to_back();
    test_reset_mid();
    test_single_slice();
    test_random_chunk4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/addsub_iter.md
# addsub_iter

Parametrised, multi-cycle two's-complement adder/subtractor for the datapath. It processes a WIDTH-bit operation in CHUNK-bit slices, one slice per clock, rippling the carry through a register between slices. It uses a start/busy/done handshake and reports carry, overflow, zero and negative flags. It is the sequential, width-generic successor to the fixed 32-bit combinational subtractor, and it serves ALU paths where area matters more than single-cycle latency.

## Interface
- WIDTH, 32: operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 8: bits processed per cycle; NCHUNK = WIDTH/CHUNK slices.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only when the block is accepting (IDLE or DONE).
- op  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while slices are being computed (state RUN).
- done  output  1  one-cycle pulse; result and flags are valid from this cycle onward.
- result  output  WIDTH  sum or difference, modulo 2^WIDTH.
- carry  output  1  carry-out of the MSB; for subtract, 1 = no borrow (a >= b unsigned).
- overflow  output  1  signed overflow of the operation.
- zero  output  1  result == 0.
- negative  output  1  result[WIDTH-1].

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 → latch a, b XOR {WIDTH{op}}, carry register = op, slice index = 0; go to RUN.
  - RUN: add slice[idx] of A and B' with the carry register. Write the CHUNK-bit sum into result[idx*CHUNK +: CHUNK]. Update the carry register with the slice carry-out. Increment idx. After slice NCHUNK-1, go to DONE.
  - DONE: done=1 for one cycle. start=1 accepts a new operation exactly as in IDLE (back-to-back) and goes to RUN; otherwise go to IDLE.
- Subtraction is A + ~B + 1. The +1 is injected as the slice-0 carry-in; no separate increment adder.
- Flags are registered on the final RUN cycle:
  - carry = final carry-out.
  - overflow = carry into MSB XOR carry out of MSB, equivalently sign(A)==sign(B') && sign(result)!=sign(A).
  - zero = result == 0.
  - negative = result MSB.
- result and flags hold their values until the next accepted start. On that start they are not cleared; they are overwritten slice by slice. Consumers read result only at or after done.
- start during RUN is ignored, with no queuing. op, a and b changes during RUN have no effect.
- CHUNK == WIDTH is legal: a single RUN cycle.

## Timing
- Reset (rst=1 at a rising edge): state = IDLE, busy = 0, done = 0, result = 0, carry = overflow = negative = 0, zero = 1, idx = 0.
- Reset applies from any state, including mid-RUN. The in-flight operation is discarded and no done is produced.
- Latency: start sampled at edge E. busy is high for cycles following edges E+1 … E+NCHUNK. done is high in the cycle following edge E+NCHUNK+1, which means NCHUNK+1 cycles after acceptance. With the defaults that is 5 cycles.
- Throughput: one operation per NCHUNK+1 cycles when start is asserted in every DONE cycle.
- busy and done are never high at the same time.

## Structure
- Package addsub_pkg holds:
  - state_t enum (IDLE, RUN, DONE);
  - OP_ADD = 1'b0, OP_SUB = 1'b1;
  - a function computing NCHUNK and its index width ($clog2, minimum 1).
- One sub-module, cla_slice #(CHUNK): combinational CHUNK-bit carry-lookahead adder with inputs a, b, cin and outputs sum, cout, c_msb (carry into the top bit, used for overflow). It is instantiated once and time-multiplexed across slices.
- The top level contains the FSM, operand registers, index counter, carry register and flag logic.

## Test plan
- Add, defaults: 0x7FFFFFFF + 0x00000001.
  - Response: result 0x80000000, overflow 1, carry 0, negative 1, zero 0.
  - Timing: done exactly 5 cycles after start, busy high for exactly 4 cycles.
- Subtract with borrow: 5 - 7.
  - Response: result 0xFFFFFFFE, carry 0, overflow 0, negative 1.
- Subtract equal: 0x12345678 - 0x12345678.
  - Response: result 0, zero 1, carry 1, overflow 0.
- Handshake:
  - start held high with new operands throughout RUN → ignored. Result matches the first operation, and exactly one done pulse is produced per accepted start.
  - start in the DONE cycle → second operation accepted back-to-back. Its done arrives 5 cycles later with the correct second result.
- Reset mid-operation: assert rst after 2 RUN cycles → next cycle is IDLE, busy 0, result 0, zero 1, no done pulse. A fresh 0x80000000 - 1 then gives 0x7FFFFFFF with overflow 1.
- Parametrisation, WIDTH=16 CHUNK=16 (single slice): 0xFFFF + 0x0001 → result 0, carry 1, zero 1, done 2 cycles after start. Repeat 1000 random ops at WIDTH=32 CHUNK=4 against a reference model.
